// File: rtl/mem_line_responder_pkg.sv
// Shared types for the cache line-fill memory responder.
// Physical pointers, cachelines, and the queued request record.
package mem_line_responder_pkg;

  localparam int PPTR_W   = 32;
  localparam int LINE_W   = 128;
  localparam int OFFSET_W = 4;

  typedef logic [PPTR_W-1:0] pptr_t;
  typedef logic [LINE_W-1:0] cacheline_t;

  typedef struct packed {
    pptr_t      addr;
    cacheline_t data;
    logic       is_write;
  } memreq_t;

  typedef enum logic {
    MEM_I = 1'b0,
    MEM_D = 1'b1
  } mem_port_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_line_responder_req_fifo.sv
// Synchronous request FIFO.
// When the FIFO is full, a pop on the same edge frees the slot for the push.
module req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: every signal gets a default before the conditionals so no latch is inferred.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = bump(wr_ptr_q);
    if (do_pop)  rd_ptr_d = bump(rd_ptr_q);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder for the cache line-fill protocol: queues I/D line requests
// and serves one at a time after a fixed access latency, with round-robin port grant.
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int LATENCY   = 5,
  parameter int QDEPTH    = 4,
  parameter int MEM_LINES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ic_req_ren,
  input  pptr_t      ic_req_addr,
  output logic       ic_rec_en,
  output pptr_t      ic_rec_addr,
  output cacheline_t ic_rec_cacheline,
  input  logic       dc_req_ren,
  input  logic       dc_req_wen,
  input  pptr_t      dc_req_addr,
  input  cacheline_t dc_req_cacheline,
  output logic       dc_rec_en,
  output pptr_t      dc_rec_addr,
  output cacheline_t dc_rec_cacheline,
  output logic       dc_wr_done,
  output logic [1:0] q_overflow
);

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int CNT_W = $clog2(LATENCY);
  // Grant edge and response edge already account for two of the LATENCY cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

  function automatic logic [IDX_W-1:0] line_idx(input pptr_t a);
    return a[IDX_W+OFFSET_W-1:OFFSET_W];
  endfunction

  // Request queues
  pptr_t      ic_head;
  memreq_t    dc_head, dc_req;
  logic       ic_full, ic_empty, ic_pop;
  logic       dc_full, dc_empty, dc_pop, dc_push;
  logic       ic_drop, dc_drop;

  assign dc_push = dc_req_ren | dc_req_wen;
  assign dc_req  = '{addr: dc_req_addr, data: dc_req_cacheline, is_write: dc_req_wen};
  assign ic_drop = ic_req_ren && ic_full && !ic_pop;
  assign dc_drop = dc_push && dc_full && !dc_pop;

  req_fifo #(.WIDTH(PPTR_W), .DEPTH(QDEPTH)) u_ic_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ic_req_ren),
    .data_i  (ic_req_addr),
    .pop_i   (ic_pop),
    .data_o  (ic_head),
    .full_o  (ic_full),
    .empty_o (ic_empty)
  );

  req_fifo #(.WIDTH($bits(memreq_t)), .DEPTH(QDEPTH)) u_dc_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (dc_push),
    .data_i  (dc_req),
    .pop_i   (dc_pop),
    .data_o  (dc_head),
    .full_o  (dc_full),
    .empty_o (dc_empty)
  );

  // Service FSM
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_port_e        last_grant_q, last_grant_d;
  mem_port_e        cur_port_q, cur_port_d;
  memreq_t          cur_q, cur_d;
  mem_port_e        grant;
  logic             pending, start, resp_fire;

  assign pending = !ic_empty || !dc_empty;
  assign grant   = (!ic_empty && !dc_empty) ? ((last_grant_q == MEM_I) ? MEM_D : MEM_I)
                 : (dc_empty ? MEM_I : MEM_D);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    cur_port_d   = cur_port_q;
    cur_d        = cur_q;
    ic_pop       = 1'b0;
    dc_pop       = 1'b0;
    resp_fire    = 1'b0;
    start        = 1'b0;
    unique case (state_q)
      ST_IDLE: start = pending;
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d   = ST_RESP;
          resp_fire = !rst;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // Chaining straight into the next grant keeps throughput at one per LATENCY.
      ST_RESP: begin
        state_d = ST_IDLE;
        start   = pending;
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d      = ST_BUSY;
      cnt_d        = CNT_LOAD;
      last_grant_d = grant;
      cur_port_d   = grant;
      if (grant == MEM_D) begin
        dc_pop = 1'b1;
        cur_d  = dc_head;
      end else begin
        ic_pop = 1'b1;
        cur_d  = '{addr: ic_head, data: '0, is_write: 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= MEM_D;
      cur_port_q   <= MEM_I;
      cur_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      cur_port_q   <= cur_port_d;
      cur_q        <= cur_d;
    end
  end

  // Backing store and response registers
  cacheline_t       store_q [MEM_LINES];
  logic [IDX_W-1:0] cur_idx;
  logic             ic_rec_en_q, dc_rec_en_q, wr_done_q;
  logic [1:0]       overflow_q;
  pptr_t            ic_rec_addr_q, dc_rec_addr_q;
  cacheline_t       ic_rec_line_q, dc_rec_line_q;
  logic             fire_ic_rd, fire_dc_rd, fire_wr;

  assign cur_idx    = line_idx(cur_q.addr);
  assign fire_wr    = resp_fire && cur_q.is_write;
  assign fire_ic_rd = resp_fire && !cur_q.is_write && (cur_port_q == MEM_I);
  assign fire_dc_rd = resp_fire && !cur_q.is_write && (cur_port_q == MEM_D);

  always_ff @(posedge clk) begin
    if (fire_wr) store_q[cur_idx] <= cur_q.data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ic_rec_en_q <= 1'b0;
      dc_rec_en_q <= 1'b0;
      wr_done_q   <= 1'b0;
      overflow_q  <= 2'b00;
    end else begin
      ic_rec_en_q <= fire_ic_rd;
      dc_rec_en_q <= fire_dc_rd;
      wr_done_q   <= fire_wr;
      overflow_q  <= overflow_q | {dc_drop, ic_drop};
    end
  end

  // Echo registers hold their last value between pulses.
  always_ff @(posedge clk) begin
    if (fire_ic_rd) begin
      ic_rec_addr_q <= cur_q.addr;
      ic_rec_line_q <= store_q[cur_idx];
    end
    if (fire_dc_rd) begin
      dc_rec_addr_q <= cur_q.addr;
      dc_rec_line_q <= store_q[cur_idx];
    end
  end

  assign ic_rec_en        = ic_rec_en_q;
  assign ic_rec_addr      = ic_rec_addr_q;
  assign ic_rec_cacheline = ic_rec_line_q;
  assign dc_rec_en        = dc_rec_en_q;
  assign dc_rec_addr      = dc_rec_addr_q;
  assign dc_rec_cacheline = dc_rec_line_q;
  assign dc_wr_done       = wr_done_q;
  assign q_overflow       = overflow_q;

endmodule
